// File: rtl/taumin_uart_packer.sv
// taumin_uart_packer
//   Frames each 11-bit taumin period from the pitch detector into a
//   self-synchronising two-byte frame for uart_transmit, honouring the
//   UART busy handshake through a one-deep pending slot.
//
//   byte0 = {1, seq[1:0], t[10:6]}   header (bit 7 set)
//   byte1 = {0, drop,     t[5:0]}    payload (bit 7 clear)
//
// Ports
//   clk_in          system clock
//   rst_in          synchronous active-high reset
//   taumin_in       period value from yin
//   valid_in        one-cycle strobe qualifying taumin_in
//   uart_busy_in    busy from uart_transmit
//   data_byte_out   byte presented to the UART (held between sends)
//   trigger_out     one-cycle send strobe
//   active_out      high while a frame is being sent
//   drop_count_out  saturating count of overwritten pending values
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | waiting for a pending value and the UART to be free
// SEND_HI  | byte0 trigger cycle, guard counter loaded
// GUARD_HI | busy ignored while the UART raises it
// WAIT_HI  | waiting for the UART to finish byte0
// SEND_LO  | byte1 trigger cycle, guard counter loaded
// GUARD_LO | busy ignored while the UART raises it
// WAIT_LO  | waiting for the UART to finish byte1, then seq advances
module taumin_uart_packer #(
  parameter int TAU_WIDTH    = 11,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [TAU_WIDTH-1:0] taumin_in,
  input  logic                 valid_in,
  input  logic                 uart_busy_in,
  output logic [7:0]           data_byte_out,
  output logic                 trigger_out,
  output logic                 active_out,
  output logic [15:0]          drop_count_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_HI,
    S_GUARD_HI,
    S_WAIT_HI,
    S_SEND_LO,
    S_GUARD_LO,
    S_WAIT_LO
  } state_t;

  // Guard counter runs from GUARD_CYCLES-1 down to 0, giving GUARD_CYCLES cycles.
  localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);

  state_t               state, state_nx;
  logic [3:0]           guard_cnt, cnt_nx;
  logic [TAU_WIDTH-1:0] pend_tau;
  logic                 pend_v;
  logic                 drop_flag;
  logic [TAU_WIDTH-1:0] frame_tau;
  logic                 frame_drop;
  logic [1:0]           seq;
  logic [7:0]           data_nx;
  logic                 trig_nx;
  logic                 consume;
  logic                 seq_inc;
  logic                 overwrite;

  // Outputs are registered from next-state values, so the trigger and its
  // byte appear in the same cycle the FSM occupies SEND_HI / SEND_LO.
  always_comb begin
    state_nx = state;
    cnt_nx   = guard_cnt;
    data_nx  = data_byte_out;
    trig_nx  = 1'b0;
    consume  = 1'b0;
    seq_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_v && !uart_busy_in) begin
          consume  = 1'b1;
          trig_nx  = 1'b1;
          // Header is built straight from the slot since the frame
          // register is only being loaded on this same edge.
          data_nx  = {1'b1, seq, pend_tau[10:6]};
          state_nx = S_SEND_HI;
        end
      end
      S_SEND_HI: begin
        cnt_nx   = GUARD_LOAD;
        state_nx = S_GUARD_HI;
      end
      S_GUARD_HI: begin
        if (guard_cnt == 4'd0) state_nx = S_WAIT_HI;
        else                   cnt_nx   = guard_cnt - 4'd1;
      end
      S_WAIT_HI: begin
        if (!uart_busy_in) begin
          trig_nx  = 1'b1;
          data_nx  = {1'b0, frame_drop, frame_tau[5:0]};
          state_nx = S_SEND_LO;
        end
      end
      S_SEND_LO: begin
        cnt_nx   = GUARD_LOAD;
        state_nx = S_GUARD_LO;
      end
      S_GUARD_LO: begin
        if (guard_cnt == 4'd0) state_nx = S_WAIT_LO;
        else                   cnt_nx   = guard_cnt - 4'd1;
      end
      S_WAIT_LO: begin
        if (!uart_busy_in) begin
          seq_inc  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // A new value landing on a full slot that is not being drained this cycle.
  assign overwrite = valid_in && pend_v && !consume;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      guard_cnt      <= 4'd0;
      data_byte_out  <= 8'd0;
      trigger_out    <= 1'b0;
      active_out     <= 1'b0;
      seq            <= 2'd0;
      frame_tau      <= '0;
      frame_drop     <= 1'b0;
      pend_tau       <= '0;
      pend_v         <= 1'b0;
      drop_flag      <= 1'b0;
      drop_count_out <= 16'd0;
    end else begin
      state         <= state_nx;
      guard_cnt     <= cnt_nx;
      data_byte_out <= data_nx;
      trigger_out   <= trig_nx;
      active_out    <= (state_nx != S_IDLE);

      if (seq_inc) seq <= seq + 2'd1;

      if (consume) begin
        frame_tau  <= pend_tau;
        frame_drop <= drop_flag;
      end

      // A strobe coinciding with consumption refills the slot.
      if (valid_in) begin
        pend_tau <= taumin_in;
        pend_v   <= 1'b1;
      end else if (consume) begin
        pend_v <= 1'b0;
      end

      if (overwrite) begin
        drop_flag <= 1'b1;
        if (drop_count_out != 16'hFFFF) drop_count_out <= drop_count_out + 16'd1;
      end else if (consume) begin
        drop_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_taumin_uart_packer.sv
module tb_taumin_uart_packer;

  localparam int G = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] taumin_in = '0;
  logic        valid_in = 1'b0;
  logic        uart_busy_in;
  logic [7:0]  data_byte_out;
  logic        trigger_out;
  logic        active_out;
  logic [15:0] drop_count_out;

  int errors = 0;
  int checks = 0;

  // UART model: busy for uart_len cycles after each trigger, plus a forced level.
  int   uart_len   = 0;
  int   busy_cnt   = 0;
  logic force_busy = 1'b0;
  logic prev_trig  = 1'b0;

  assign uart_busy_in = force_busy | (busy_cnt != 0);

  taumin_uart_packer #(.TAU_WIDTH(11), .GUARD_CYCLES(G)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .taumin_in      (taumin_in),
    .valid_in       (valid_in),
    .uart_busy_in   (uart_busy_in),
    .data_byte_out  (data_byte_out),
    .trigger_out    (trigger_out),
    .active_out     (active_out),
    .drop_count_out (drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (rst_in)                busy_cnt <= 0;
    else if (trigger_out)      busy_cnt <= uart_len;
    else if (busy_cnt != 0)    busy_cnt <= busy_cnt - 1;
  end

  // Trigger must never coincide with busy, nor repeat on consecutive cycles.
  always @(negedge clk_in) begin
    if (trigger_out === 1'b1) begin
      checks++;
      if (uart_busy_in || prev_trig) begin
        errors++;
        $display("FAIL trig_guard: trigger with busy=%0b prev_trig=%0b, required both 0",
                 uart_busy_in, prev_trig);
      end
    end
    prev_trig <= trigger_out;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst_in     = 1'b1;
    valid_in   = 1'b0;
    force_busy = 1'b0;
    repeat (3) tick();
    rst_in = 1'b0;
  endtask

  task automatic wait_trig(input int limit, output int n, output bit ok);
    n = 0;
    while (trigger_out !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    ok = (trigger_out === 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (active_out !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    check(name, active_out, 0);
  endtask

  typedef struct {
    logic [10:0] tau;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  // Single frame with busy held low: fixed latency and minimum byte spacing.
  task automatic run_vec(input vec_t v);
    int n;
    bit ok;
    valid_in  = 1'b1;
    taumin_in = v.tau;
    tick();
    valid_in = 1'b0;
    check("lat_n1_trig", trigger_out, 0);
    check("lat_n1_active", active_out, 0);
    tick();
    check("b0_trig", trigger_out, 1);
    check("b0_data", data_byte_out, v.b0);
    check("b0_active", active_out, 1);
    tick();
    wait_trig(40, n, ok);
    check("b1_seen", ok, 1);
    check("b1_spacing", n + 1, G + 2);
    check("b1_data", data_byte_out, v.b1);
    tick();
    wait_idle("vec_idle");
    check("vec_hold_data", data_byte_out, v.b1);
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] b;
  } exp_t;

  // Random traffic against a timeline model: frame start is the first cycle the
  // link is free with a value pending; byte1 and link release follow from the
  // guard length and the UART busy time.
  task automatic run_random(input int len_l, input int ncyc);
    exp_t        exp_q[$];
    logic [10:0] m_pend;
    bit          m_pv, m_df, v, consume;
    logic [1:0]  m_seq;
    int          m_drops, m_start, m_idle_from, m_len, tb0, tb1;
    logic [10:0] t;
    m_len = (len_l > G) ? len_l : G;
    m_pend = '0; m_pv = 0; m_df = 0; m_seq = 0; m_drops = 0;
    m_start = 0; m_idle_from = 0;
    do_reset();
    uart_len = len_l;
    for (int c = 0; c < ncyc; c++) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        check("rnd_trig", trigger_out, 1);
        check("rnd_byte", data_byte_out, exp_q[0].b);
        void'(exp_q.pop_front());
      end else begin
        check("rnd_no_trig", trigger_out, 0);
      end
      check("rnd_drops", drop_count_out, m_drops);
      check("rnd_active", active_out, (c >= m_start && c < m_idle_from));

      v = ($urandom_range(0, 5) == 0);
      t = 11'($urandom_range(0, 2047));
      valid_in  = v;
      taumin_in = t;

      consume = m_pv && (c >= m_idle_from) && !uart_busy_in;
      if (consume) begin
        tb0 = c + 1;
        tb1 = tb0 + m_len + 2;
        exp_q.push_back('{tb0, {1'b1, m_seq, m_pend[10:6]}});
        exp_q.push_back('{tb1, {1'b0, m_df, m_pend[5:0]}});
        m_seq++;
        m_start     = tb0;
        m_idle_from = tb1 + m_len + 2;
        m_df = 0;
        m_pv = 0;
      end
      if (v) begin
        if (m_pv) begin
          m_df = 1;
          if (m_drops < 65535) m_drops++;
        end
        m_pv   = 1;
        m_pend = t;
      end
      tick();
    end
    valid_in = 1'b0;
  endtask

  // Drive a value list at given cycles and collect every byte sent.
  task automatic collect(input int ncyc, input int c1, input logic [10:0] t1,
                         input int c2, input logic [10:0] t2, input int c3, input logic [10:0] t3,
                         input int c4, input logic [10:0] t4, output logic [7:0] got[$]);
    got = {};
    for (int c = 0; c < ncyc; c++) begin
      if (trigger_out === 1'b1) got.push_back(data_byte_out);
      valid_in = 1'b1;
      if      (c == c1) taumin_in = t1;
      else if (c == c2) taumin_in = t2;
      else if (c == c3) taumin_in = t3;
      else if (c == c4) taumin_in = t4;
      else              valid_in = 1'b0;
      tick();
    end
    valid_in = 1'b0;
  endtask

  initial begin
    vec_t        vecs[6];
    logic [7:0]  got[$];
    logic [7:0]  want[$];
    int          n;
    bit          ok, saw;

    vecs[0] = '{11'd1234, 8'h93, 8'h12};
    vecs[1] = '{11'd2047, 8'hBF, 8'h3F};
    vecs[2] = '{11'd5,    8'hC0, 8'h05};
    vecs[3] = '{11'd0,    8'hE0, 8'h00};
    vecs[4] = '{11'd64,   8'h81, 8'h00};
    vecs[5] = '{11'd1023, 8'hAF, 8'h3F};

    // Reset state
    do_reset();
    check("rst_data", data_byte_out, 0);
    check("rst_trig", trigger_out, 0);
    check("rst_active", active_out, 0);
    check("rst_drops", drop_count_out, 0);

    // Table: single frames, seq fields 0,1,2,3,0
    uart_len = 0;
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    check("table_drops", drop_count_out, 0);

    // Realistic UART: 2047 then 5 while the first frame is in flight
    do_reset();
    uart_len = 100;
    collect(1000, 0, 11'd2047, 10, 11'd5, -1, 11'd0, -1, 11'd0, got);
    want = '{8'h9F, 8'h3F, 8'hA0, 8'h05};
    check("uart_nbytes", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("uart_byte", got[i], want[i]);
    check("uart_drops", drop_count_out, 0);

    // Burst: 100 is taken at once, 200 refills on the consume cycle, 300 overwrites
    do_reset();
    uart_len = 20;
    collect(600, 0, 11'd100, 1, 11'd200, 2, 11'd300, 300, 11'd7, got);
    want = '{8'h81, 8'h24, 8'hA4, 8'h6C, 8'hC0, 8'h07};
    check("burst_nbytes", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) check("burst_byte", got[i], want[i]);
    check("burst_drops", drop_count_out, 1);

    // Busy at start: frame waits for busy low plus the decision cycle
    do_reset();
    uart_len   = 0;
    force_busy = 1'b1;
    valid_in   = 1'b1;
    taumin_in  = 11'd1234;
    saw = 0;
    for (int i = 0; i < 50; i++) begin
      if (trigger_out === 1'b1) saw = 1;
      tick();
      valid_in = 1'b0;
    end
    check("busy_no_trig", saw, 0);
    force_busy = 1'b0;
    check("busy_fall_cycle", trigger_out, 0);
    tick();
    check("busy_trig", trigger_out, 1);
    check("busy_b0", data_byte_out, 8'h93);
    tick();
    wait_idle("busy_idle");

    // Reset mid-frame, in WAIT_HI
    do_reset();
    uart_len  = 100;
    valid_in  = 1'b1;
    taumin_in = 11'd1234;
    tick();
    valid_in = 1'b0;
    wait_trig(10, n, ok);
    check("midrst_b0_seen", ok, 1);
    repeat (10) tick();
    check("midrst_active_before", active_out, 1);
    rst_in = 1'b1;
    tick();
    check("midrst_data", data_byte_out, 0);
    check("midrst_trig", trigger_out, 0);
    check("midrst_active", active_out, 0);
    check("midrst_drops", drop_count_out, 0);
    rst_in   = 1'b0;
    uart_len = 0;
    tick();
    check("midrst_after_trig", trigger_out, 0);
    run_vec('{11'd7, 8'h80, 8'h07});

    // Random traffic against the reference model
    run_random(0, 2000);
    run_random($urandom_range(3, 12), 2000);

    // Saturation: 70000 overwrites with the link held busy
    do_reset();
    force_busy = 1'b1;
    for (int i = 0; i <= 70000; i++) begin
      valid_in  = 1'b1;
      taumin_in = 11'($urandom_range(0, 2047));
      tick();
      if (i == 65534) check("sat_fffe", drop_count_out, 16'hFFFE);
      if (i == 65535) check("sat_ffff", drop_count_out, 16'hFFFF);
    end
    valid_in = 1'b0;
    tick();
    check("sat_hold", drop_count_out, 16'hFFFF);
    check("sat_no_trig", trigger_out, 0);
    force_busy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/taumin_uart_packer.md
# taumin_uart_packer

Framing stage between the `yin` pitch detector and `uart_transmit`. It sends every detected 11-bit `taumin` period to the host as a self-synchronising two-byte frame, so no period bits are truncated. It obeys the UART `busy` handshake and keeps a one-deep pending slot. When new values arrive faster than the link can send them, older ones are overwritten, and each overwrite is counted and flagged in the stream.

## Interface

Parameters:
- `TAU_WIDTH`, default 11. Width of the period input. Fixed at 11 by the frame format.
- `GUARD_CYCLES`, default 2. Cycles after each `trigger_out` during which `uart_busy_in` is ignored, so the UART has time to raise `busy`. Legal range 1..15.

Ports:
- `clk_in`, input, 1 bit. System clock (100 MHz).
- `rst_in`, input, 1 bit. Reset, synchronous and active-high.
- `taumin_in`, input, 11 bits. Period from `yin`.
- `valid_in`, input, 1 bit. One-cycle strobe marking `taumin_in` valid.
- `uart_busy_in`, input, 1 bit. `busy_out` of `uart_transmit`.
- `data_byte_out`, output, 8 bits. Byte to transmit. Connects to `data_byte_in`.
- `trigger_out`, output, 1 bit. One-cycle send strobe. Connects to `trigger_in`.
- `active_out`, output, 1 bit. High whenever the FSM is not in IDLE.
- `drop_count_out`, output, 16 bits. Saturating count of overwritten values.

## Operation

Frame format for value `t`, with sequence number `seq` and drop flag `d`:
- byte0 = {1, seq[1:0], t[10:6]}.
- byte1 = {0, d, t[5:0]}.
- Bit 7 marks the frame header, so the host resynchronises on any byte with bit 7 set.
- `seq` is a 2-bit counter. It increments, wrapping 3→0, when a frame's byte1 completes.

Pending slot:
- On every `valid_in`, `taumin_in` is written into the pending register and `pend_v` is set.
- If `pend_v` was already 1 and the slot is not being consumed in that same cycle, this is an overwrite:
  - set the sticky `drop_flag`;
  - increment `drop_count_out`, saturating at 16'hFFFF.
- If `valid_in` arrives in the same cycle the slot is consumed, the new value refills the slot (`pend_v` stays 1) and no drop is counted.

FSM states: IDLE, SEND_HI, GUARD_HI, WAIT_HI, SEND_LO, GUARD_LO, WAIT_LO.
- IDLE: when `pend_v` is 1 and `uart_busy_in` is 0:
  - latch the frame register from the pending slot and `drop_flag`;
  - clear `pend_v` and `drop_flag`;
  - go to SEND_HI.
- SEND_HI: `data_byte_out` = byte0 and `trigger_out` = 1 for this one cycle. Load the guard counter, then go to GUARD_HI.
- GUARD_HI: count down `GUARD_CYCLES` cycles, ignoring busy, then go to WAIT_HI.
- WAIT_HI: stay until `uart_busy_in` is 0, then go to SEND_LO.
- SEND_LO, GUARD_LO, WAIT_LO: same as the three states above, using byte1.
- Leaving WAIT_LO: increment `seq` and go to IDLE.

Outputs and counters:
- `data_byte_out` holds its last value between sends.
- `trigger_out` is never high for two consecutive cycles.
- `drop_count_out` clears only on reset.

Reset:
- Sets state to IDLE and clears `pend_v`, `drop_flag`, `seq`, the frame register and all outputs.
- Reset asserted mid-frame abandons the frame. No trigger is issued in the cycle after reset deasserts.

## Timing

- All outputs are registered.
- Reset values: `data_byte_out` = 0, `trigger_out` = 0, `active_out` = 0, `drop_count_out` = 0.
- Latency, with the FSM in IDLE, `pend_v` = 0 and busy low:
  - `valid_in` in cycle N sets `pend_v` at N+1;
  - `trigger_out` (byte0) is high in cycle N+2;
  - `active_out` is high from N+2.
- Minimum spacing between byte0 and byte1 triggers: `GUARD_CYCLES` + 2 cycles, reached when busy never rises.
- If `uart_busy_in` is high while in IDLE, the frame start waits until busy is low.
- Throughput: one frame per two UART byte times. Any values arriving in between collapse into the pending slot, and only the latest is sent.

## Test plan

- **Single value:** `taumin_in` = 1234 with busy held low → `trigger_out` in cycle N+2 with 0x93. Second trigger with 0x12. `drop_count_out` = 0. `seq` then reads 1.
- **Realistic UART:** connect a UART model with busy high for 100 cycles after each trigger. Send 2047 then 5 → frames 0x9F, 0x3F then 0xA0, 0x05 (seq = 1). Trigger is never asserted while busy is high.
- **Burst overwrite:** send 100, 200, 300 in consecutive cycles while a frame is in flight → `drop_count_out` = 1. The next frame carries 300 with byte1 bit 6 = 1. The following frame has bit 6 = 0.
- **Busy at start:** hold busy high for 50 cycles while a value is pending → no trigger until the cycle after busy falls, plus the IDLE decision cycle. Byte0 is correct.
- **Reset mid-frame:** assert `rst_in` during WAIT_HI → all outputs 0 the next cycle and `seq` = 0. After release, a new value 7 produces 0x80, 0x07.
- **Sequence wrap and saturation:** send 5 frames → `seq` fields read 0, 1, 2, 3, 0. Force 70000 overwrites → `drop_count_out` holds at 0xFFFF.
